sram_core: RTL and testbench



---
 rtl/sram_core_pkg.sv | 12 +
 rtl/sram_core_if.sv | 26 ++
 rtl/sram_core_init_seq.sv | 44 ++++
 rtl/sram_core.sv | 82 ++++++++
 tb/tb_sram_core.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/sram_core_pkg.sv
// Shared SRAM sizing defaults and init-sequencer state encoding.
// No logic; widths and states only.
package sram_core_pkg;
  localparam int SRAM_DATA_WIDTH = 64;
  localparam int SRAM_ADDR_WIDTH = 32;
  localparam int SRAM_DEPTH      = 1024;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } sram_state_e;
endpackage

// File: rtl/sram_core_if.sv
// Active-low SRAM access port (enable, write enable, byte mask) plus read data and init status.
// The controller may only issue accesses once init_done_o is high; nothing is back-pressured.
interface sram_core_if
  import sram_core_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH
) ();
  logic                    en_i;
  logic                    wen_i;
  logic [DATA_WIDTH/8-1:0] bm_i;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic [DATA_WIDTH-1:0]   dat_i;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic                    init_done_o;

  modport master (
    output en_i, wen_i, bm_i, addr_i, dat_i,
    input  dat_o, init_done_o
  );

  modport slave (
    input  en_i, wen_i, bm_i, addr_i, dat_i,
    output dat_o, init_done_o
  );
endinterface

// File: rtl/sram_core_init_seq.sv
// Post-reset sweep: one array word per cycle for DEPTH cycles, then READY until the next reset.
// init_done_o is a decode of the state register, high from the cycle after the last sweep write.
module sram_core_init_seq
  import sram_core_pkg::*;
#(
  parameter int DEPTH = SRAM_DEPTH
) (
  input  logic                     aclk_i,
  input  logic                     aresetn_i,
  output logic                     init_we_o,
  output logic [$clog2(DEPTH)-1:0] init_idx_o,
  output logic                     init_done_o
);
  localparam int IDX = $clog2(DEPTH);

  sram_state_e    state_q, state_d;
  logic [IDX-1:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == ST_INIT) begin
      // Counter wraps to zero on the last word since DEPTH is a power of two.
      idx_d = idx_q + 1'b1;
      if (idx_q == IDX'(DEPTH - 1)) begin
        state_d = ST_READY;
      end
    end
  end

  always_ff @(posedge aclk_i) begin
    if (!aresetn_i) begin
      state_q <= ST_INIT;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign init_we_o   = (state_q == ST_INIT);
  assign init_idx_o  = idx_q;
  assign init_done_o = (state_q == ST_READY);
endmodule

// File: rtl/sram_core.sv
// Single-port byte-maskable SRAM with post-reset INIT_VAL sweep; read latency 1 cycle.
// No backpressure: dat_o holds between reads, and accesses before init_done_o are dropped.
module sram_core
  import sram_core_pkg::*;
#(
  parameter int                    DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int                    ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int                    DEPTH      = SRAM_DEPTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input logic        aclk_i,
  input logic        aresetn_i,
  sram_core_if.slave bus
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFS = $clog2(NB);
  localparam int IDX = $clog2(DEPTH);

  logic                  init_we;
  logic                  init_done;
  logic [IDX-1:0]        init_idx;
  logic [IDX-1:0]        acc_idx;
  logic                  acc_wr;
  logic                  acc_rd;
  logic [IDX-1:0]        wr_idx;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] wr_dat;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  unused_addr;

  sram_core_init_seq #(.DEPTH(DEPTH)) u_init_seq (
    .aclk_i      (aclk_i),
    .aresetn_i   (aresetn_i),
    .init_we_o   (init_we),
    .init_idx_o  (init_idx),
    .init_done_o (init_done)
  );

  // Only the word-index bits matter; offset and alias bits are deliberately dropped.
  assign unused_addr = ^bus.addr_i;

  always_comb begin
    acc_idx = bus.addr_i[OFS +: IDX];
    acc_wr  = aresetn_i && init_done && !bus.en_i && !bus.wen_i;
    acc_rd  = init_done && !bus.en_i && bus.wen_i;
    wr_idx  = acc_idx;
    wr_be   = acc_wr ? ~bus.bm_i : '0;
    wr_dat  = bus.dat_i;
    if (init_we && aresetn_i) begin
      wr_idx = init_idx;
      wr_be  = '1;
      wr_dat = INIT_VAL;
    end

    dat_d = dat_q;
    if (!init_done) begin
      dat_d = '0;
    end else if (acc_rd) begin
      dat_d = mem[acc_idx];
    end
  end

  always_ff @(posedge aclk_i) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_be[b]) begin
        mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge aclk_i) begin
    if (!aresetn_i) begin
      dat_q <= '0;
    end else begin
      dat_q <= dat_d;
    end
  end

  assign bus.dat_o       = dat_q;
  assign bus.init_done_o = init_done;
endmodule

// File: tb/tb_sram_core.sv
// Random and directed accesses against an edge-counting array model of the SRAM.
module tb_sram_core;
  import sram_core_pkg::*;

  localparam int          DW    = 64;
  localparam int          AW    = 32;
  localparam int          DEPTH = 1024;
  localparam logic [63:0] INIT  = 64'hDEAD_BEEF_0000_0000;

  logic clk = 1'b0;
  logic rstn;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  sram_core_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sram_core #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .INIT_VAL   (INIT)
  ) dut (
    .aclk_i    (clk),
    .aresetn_i (rstn),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Model: count edges since reset release; the first DEPTH of them are the sweep.
  logic [63:0] m_mem [DEPTH];
  logic [63:0] m_dat;
  int          m_cnt;

  always @(posedge clk) begin
    int idx;
    if (!rstn) begin
      m_cnt = 0;
      m_dat = '0;
    end else if (m_cnt < DEPTH) begin
      m_mem[m_cnt] = INIT;
      m_cnt++;
      m_dat = '0;
    end else if (!bus.en_i) begin
      idx = int'((bus.addr_i / 8) % DEPTH);
      if (!bus.wen_i) begin
        for (int b = 0; b < 8; b++)
          if (!bus.bm_i[b]) m_mem[idx][8*b +: 8] = bus.dat_i[8*b +: 8];
      end else begin
        m_dat = m_mem[idx];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (bus.dat_o !== m_dat) begin
        fails++;
        $display("FAIL model_dat t=%0t got=%h exp=%h", $time, bus.dat_o, m_dat);
      end
      tests++;
      if (bus.init_done_o !== (m_cnt >= DEPTH)) begin
        fails++;
        $display("FAIL model_done t=%0t got=%b exp=%b", $time, bus.init_done_o, (m_cnt >= DEPTH));
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic wen, input logic [7:0] bm,
                       input logic [31:0] addr, input logic [63:0] d);
    bus.en_i   = en;
    bus.wen_i  = wen;
    bus.bm_i   = bm;
    bus.addr_i = addr;
    bus.dat_i  = d;
    step();
  endtask

  task automatic idle();
    drive(1'b1, 1'b1, 8'hFF, 32'h0, 64'h0);
  endtask

  task automatic rd(input logic [31:0] addr);
    drive(1'b0, 1'b1, 8'h00, addr, 64'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [7:0] bm, input logic [63:0] d);
    drive(1'b0, 1'b0, bm, addr, d);
  endtask

  task automatic rand_access(input int en_pct);
    logic [31:0] a;
    a = ($urandom & 32'hFFFF_E007) | (32'($urandom_range(0, 15)) << 3);
    drive(($urandom_range(0, 99) >= en_pct), 1'($urandom), 8'($urandom), a,
          {$urandom, $urandom});
  endtask

  initial begin
    rstn       = 1'b0;
    bus.en_i   = 1'b1;
    bus.wen_i  = 1'b1;
    bus.bm_i   = 8'hFF;
    bus.addr_i = '0;
    bus.dat_i  = '0;
    step();
    chk_en = 1'b1;
    step();
    step();
    check("reset_dat", bus.dat_o, 64'h0);
    check("reset_done", 64'(bus.init_done_o), 64'h0);

    // Sweep with junk accesses presented; all of them must be dropped.
    rstn = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      rand_access(50);
      if (k == 1022) begin
        check("done_edge1022", 64'(bus.init_done_o), 64'h0);
        check("init_dat_zero", bus.dat_o, 64'h0);
      end
      if (k == 1023) check("done_edge1023", 64'(bus.init_done_o), 64'h1);
    end

    rd(32'h0);      check("init_idx0", bus.dat_o, INIT);
    rd(32'h0FF8);   check("init_idx511", bus.dat_o, INIT);
    rd(32'h1FF8);   check("init_idx1023", bus.dat_o, INIT);

    wr(32'h10, 8'h00, 64'h0123_4567_89AB_CDEF);
    rd(32'h10);     check("full_write", bus.dat_o, 64'h0123_4567_89AB_CDEF);
    wr(32'h10, 8'hF0, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(32'h10);     check("masked_write", bus.dat_o, 64'h0123_4567_FFFF_FFFF);
    wr(32'h10, 8'hFF, 64'h0);
    rd(32'h2010);   check("alias_read", bus.dat_o, 64'h0123_4567_FFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      idle();
      check("idle_hold", bus.dat_o, 64'h0123_4567_FFFF_FFFF);
    end
    wr(32'h18, 8'h00, 64'hA5A5_5A5A_1234_5678);
    check("write_keeps_dat", bus.dat_o, 64'h0123_4567_FFFF_FFFF);
    rd(32'h18);     check("raw_next_cycle", bus.dat_o, 64'hA5A5_5A5A_1234_5678);

    for (int i = 0; i < 1500; i++) rand_access(25);
    for (int i = 0; i < 20; i++) idle();

    // Reset from READY, then again partway through the sweep.
    rstn = 1'b0;
    idle();
    check("midop_reset_dat", bus.dat_o, 64'h0);
    check("midop_reset_done", 64'(bus.init_done_o), 64'h0);
    idle();
    rstn = 1'b1;
    for (int k = 0; k < 300; k++) idle();
    rstn = 1'b0;
    idle();
    rstn = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 5) wr(32'h10, 8'h00, 64'h0000_0BAD_0000_0BAD);
      else idle();
      if (k == 1022) check("restart_done1022", 64'(bus.init_done_o), 64'h0);
      if (k == 1023) check("restart_done1023", 64'(bus.init_done_o), 64'h1);
    end
    rd(32'h10);     check("dropped_write", bus.dat_o, INIT);
    rd(32'h18);     check("resweep_idx3", bus.dat_o, INIT);
    idle();
    idle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
